// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the pipeline memory stage and a
// synchronous single-port SRAM. It accepts one load or store at a time. An
// in-range access spends one ACCESS cycle on the SRAM, then WAIT_CYCLES wait
// cycles, then one DONE cycle. An out-of-range access goes straight to DONE
// with an error flag and never touches the SRAM.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   dmem_read/write     : load/store request, held until resp_done
//   mem_addr, mem_wdata : byte address and store data of the request
//   resp_rdata          : load data (0 for stores and errors)
//   resp_done, resp_err : one-cycle completion pulse / out-of-range flag
//   busy                : high whenever the controller is not IDLE
//   sram_ce/we/addr/wdata, sram_rdata : SRAM port (read data one cycle after ce)
module dmem_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       resp_rdata,
    output logic              resp_done,
    output logic              resp_err,
    output logic              busy,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;

    logic                w_req;
    logic                w_in_range;
    logic                w_accept;
    logic                w_first_wait;

    assign w_req        = dmem_read | dmem_write;
    // Everything above the word-address field must be zero; the byte offset
    // bits [1:0] play no part in the range test or the word address.
    assign w_in_range   = (mem_addr >> (ADDR_W + 2)) == 32'd0;
    assign w_accept     = (r_state == S_IDLE) && w_req;
    // The counter is loaded with CNT_LOAD on entry and only counts down, so
    // holding CNT_LOAD inside WAIT identifies the first wait cycle.
    assign w_first_wait = (r_state == S_WAIT) && (r_cnt == CNT_LOAD);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = w_in_range ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: w_next = S_WAIT;
            S_WAIT:   w_next = (r_cnt == 4'd0) ? S_DONE : S_WAIT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request capture, wait counter and read-data register. These are all
    // cleared by reset because they drive the outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                // Write wins when both request lines are high.
                r_we    <= dmem_write;
                r_addr  <= mem_addr[ADDR_W+1:2];
                r_wdata <= mem_wdata;
                r_err   <= ~w_in_range;
                // An error response carries zero data, so clear it here;
                // in-range accesses update it in their first wait cycle.
                if (!w_in_range) begin
                    r_rdata <= 32'd0;
                end
            end

            if (r_state == S_ACCESS) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // SRAM data is valid in the cycle after ce; stores return zero.
            if (w_first_wait) begin
                r_rdata <= r_we ? 32'd0 : sram_rdata;
            end
        end
    end

    // Output logic
    always_comb begin
        sram_ce    = (r_state == S_ACCESS);
        sram_we    = (r_state == S_ACCESS) && r_we;
        sram_addr  = r_addr;
        sram_wdata = r_wdata;
        resp_done  = (r_state == S_DONE);
        resp_err   = (r_state == S_DONE) && r_err;
        busy       = (r_state != S_IDLE);
        resp_rdata = r_rdata;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

    localparam int AW = 14;
    localparam int W0 = 2;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    exp_t sb[$];

    // Main DUT (WAIT_CYCLES = 2)
    logic          dmem_read = 1'b0;
    logic          dmem_write = 1'b0;
    logic [31:0]   mem_addr = 32'd0;
    logic [31:0]   mem_wdata = 32'd0;
    logic [31:0]   resp_rdata;
    logic          resp_done, resp_err, busy;
    logic          sram_ce, sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   srd0 = 32'd0;

    dmem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W0)) dut (
        .clk(clk), .rst(rst), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .resp_rdata(resp_rdata),
        .resp_done(resp_done), .resp_err(resp_err), .busy(busy),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(srd0)
    );

    // Sweep DUTs (WAIT_CYCLES = 1 and 15), read-only traffic
    logic          rd1 = 1'b0, rd15 = 1'b0;
    logic [31:0]   addr_s = 32'd0;
    logic [31:0]   rdata1, rdata15, wdata1, wdata15;
    logic          done1, done15, err1, err15, busy1, busy15;
    logic          ce1, ce15, we1, we15;
    logic [AW-1:0] sa1, sa15;
    logic [31:0]   srd1 = 32'd0, srd15 = 32'd0;

    dmem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .dmem_read(rd1), .dmem_write(1'b0),
        .mem_addr(addr_s), .mem_wdata(32'd0), .resp_rdata(rdata1),
        .resp_done(done1), .resp_err(err1), .busy(busy1),
        .sram_ce(ce1), .sram_we(we1), .sram_addr(sa1),
        .sram_wdata(wdata1), .sram_rdata(srd1)
    );

    dmem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .rst(rst), .dmem_read(rd15), .dmem_write(1'b0),
        .mem_addr(addr_s), .mem_wdata(32'd0), .resp_rdata(rdata15),
        .resp_done(done15), .resp_err(err15), .busy(busy15),
        .sram_ce(ce15), .sram_we(we15), .sram_addr(sa15),
        .sram_wdata(wdata15), .sram_rdata(srd15)
    );

    // Initial SRAM contents for words never written
    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        if (a == 14'h10) return 32'hDEADBEEF;
        if (a == 14'h12) return 32'hCAFEF00D;
        return {18'h0, a} ^ 32'h5A5A0000;
    endfunction

    // SRAM models: synchronous, read data registered on the ce edge
    logic [31:0] mem0 [0:(1<<AW)-1];
    bit          wr0  [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                mem0[sram_addr] <= sram_wdata;
                wr0[sram_addr]  <= 1'b1;
            end else begin
                srd0 <= wr0[sram_addr] ? mem0[sram_addr] : pat(sram_addr);
            end
        end
    end
    always @(posedge clk) if (ce1)  srd1  <= pat(sa1);
    always @(posedge clk) if (ce15) srd15 <= pat(sa15);

    // Scoreboard monitor for the main DUT
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && resp_done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: cycle %0d rdata %08h err %0b, expected no response",
                         cyc, resp_rdata, resp_err);
            end else begin
                e = sb.pop_front();
                if (32'(cyc) !== e.cyc) begin
                    n_fail++;
                    $display("FAIL sb_done_cycle: got %0d expected %0d", cyc, e.cyc);
                end
                n_cmp++;
                if (resp_rdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL sb_rdata: got %08h expected %08h", resp_rdata, e.rd);
                end
                n_cmp++;
                if (resp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_err: got %0b expected %0b", resp_err, e.err);
                end
            end
        end
    end

    // Drive one transaction, push its expectation, wait for done (bounded)
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          output logic seen, output int ce_n, output logic [AW-1:0] sa,
                          output logic swe, output logic [31:0] swd);
        int t;
        @(posedge clk); #1;
        dmem_read = rd; dmem_write = wr; mem_addr = addr; mem_wdata = wd;
        t = cyc;
        sb.push_back('{exp_rd, exp_err, 32'(t + (exp_err ? 1 : 2 + W0))});
        seen = 1'b0; ce_n = 0; sa = '0; swe = 1'b0; swd = 32'd0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (sram_ce) begin
                ce_n++; sa = sram_addr; swe = sram_we; swd = sram_wdata;
            end
            if (resp_done) seen = 1'b1;
        end
        @(posedge clk); #1;
        dmem_read = 1'b0; dmem_write = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if ({resp_rdata, resp_done, resp_err, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_resp: got %08h/%0b/%0b/%0b expected all 0", resp_rdata, resp_done, resp_err, busy);
        end
        n_cmp++;
        if ({sram_ce, sram_we, sram_addr, sram_wdata} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_sram: got ce %0b we %0b addr %h wdata %h expected all 0", sram_ce, sram_we, sram_addr, sram_wdata);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %0b expected 0", busy);
        end
    endtask

    task automatic test_read();
        logic seen, swe; int ce_n; logic [AW-1:0] sa; logic [31:0] swd;
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, seen, ce_n, sa, swe, swd);
        n_cmp++;
        if (seen !== 1'b1 || ce_n != 1) begin
            n_fail++;
            $display("FAIL read_done_ce: got done %0b ce cycles %0d expected 1/1", seen, ce_n);
        end
        n_cmp++;
        if (sa !== 14'h10 || swe !== 1'b0) begin
            n_fail++;
            $display("FAIL read_sram_addr_we: got %h/%0b expected 0010/0", sa, swe);
        end
        @(negedge clk);
        n_cmp++;
        if (resp_rdata !== 32'hDEADBEEF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_hold_idle: got rdata %08h busy %0b expected deadbeef/0", resp_rdata, busy);
        end
        // Byte offset bits are ignored
        do_txn(1'b1, 1'b0, 32'h43, 32'h0, 32'hDEADBEEF, 1'b0, seen, ce_n, sa, swe, swd);
        n_cmp++;
        if (sa !== 14'h10) begin
            n_fail++;
            $display("FAIL read_unaligned_addr: got %h expected 0010", sa);
        end
    endtask

    task automatic test_write_read();
        logic seen, swe; int ce_n; logic [AW-1:0] sa; logic [31:0] swd;
        do_txn(1'b0, 1'b1, 32'h44, 32'h12345678, 32'h0, 1'b0, seen, ce_n, sa, swe, swd);
        n_cmp++;
        if (seen !== 1'b1 || ce_n != 1 || swe !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ce_we: got done %0b ce %0d we %0b expected 1/1/1", seen, ce_n, swe);
        end
        n_cmp++;
        if (sa !== 14'h11 || swd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_addr_data: got %h/%08h expected 0011/12345678", sa, swd);
        end
        n_cmp++;
        if (mem0[14'h11] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_sram_content: got %08h expected 12345678", mem0[14'h11]);
        end
        do_txn(1'b1, 1'b0, 32'h44, 32'h0, 32'h12345678, 1'b0, seen, ce_n, sa, swe, swd);
        n_cmp++;
        if (seen !== 1'b1 || sa !== 14'h11) begin
            n_fail++;
            $display("FAIL readback: got done %0b addr %h expected 1/0011", seen, sa);
        end
    endtask

    task automatic test_out_of_range();
        logic seen, swe; int ce_n; logic [AW-1:0] sa; logic [31:0] swd;
        // Highest in-range word
        do_txn(1'b1, 1'b0, 32'h0000_FFFC, 32'h0, pat(14'h3FFF), 1'b0, seen, ce_n, sa, swe, swd);
        n_cmp++;
        if (ce_n != 1 || sa !== 14'h3FFF) begin
            n_fail++;
            $display("FAIL range_top_word: got ce %0d addr %h expected 1/3fff", ce_n, sa);
        end
        do_txn(1'b1, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, seen, ce_n, sa, swe, swd);
        n_cmp++;
        if (seen !== 1'b1 || ce_n != 0) begin
            n_fail++;
            $display("FAIL oor_read: got done %0b ce cycles %0d expected 1/0", seen, ce_n);
        end
        do_txn(1'b0, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 32'h0, 1'b1, seen, ce_n, sa, swe, swd);
        n_cmp++;
        if (seen !== 1'b1 || ce_n != 0 || wr0[14'h10] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_write: got done %0b ce %0d wrote %0b expected 1/0/0", seen, ce_n, wr0[14'h10]);
        end
    endtask

    task automatic test_ignore_changes();
        logic seen; int ce_n; logic [AW-1:0] sa; logic swe;
        @(posedge clk); #1;
        dmem_read = 1'b1; mem_addr = 32'h40;
        sb.push_back('{32'hDEADBEEF, 1'b0, 32'(cyc + 2 + W0)});
        @(posedge clk); #1;
        dmem_read = 1'b0; dmem_write = 1'b1; mem_addr = 32'h48; mem_wdata = 32'hFFFF_FFFF;
        seen = 1'b0; ce_n = 0; sa = '0; swe = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (sram_ce) begin ce_n++; sa = sram_addr; swe = sram_we; end
            if (resp_done) seen = 1'b1;
            dmem_write = 1'b0;
        end
        n_cmp++;
        if (seen !== 1'b1 || ce_n != 1 || sa !== 14'h10 || swe !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_changes: got done %0b ce %0d addr %h we %0b expected 1/1/0010/0", seen, ce_n, sa, swe);
        end
        n_cmp++;
        if (wr0[14'h12] !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_write: got written %0b expected 0", wr0[14'h12]);
        end
    endtask

    task automatic test_back_to_back();
        int t, d1, d2, ce_n;
        @(posedge clk); #1;
        dmem_read = 1'b1; mem_addr = 32'h40; t = cyc;
        sb.push_back('{32'hDEADBEEF, 1'b0, 32'(t + 2 + W0)});
        sb.push_back('{32'hCAFEF00D, 1'b0, 32'(t + 2 * (2 + W0) + 1)});
        d1 = -1; d2 = -1; ce_n = 0;
        for (int i = 0; i < 60 && d2 < 0; i++) begin
            @(negedge clk);
            if (sram_ce) ce_n++;
            if (resp_done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    @(posedge clk); #1;
                    mem_addr = 32'h48;
                end else begin
                    d2 = cyc;
                end
            end
        end
        @(posedge clk); #1;
        dmem_read = 1'b0;
        n_cmp++;
        if (d1 < 0 || d2 < 0 || (d2 - d1) != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing: got done cycles %0d,%0d expected 5 apart", d1, d2);
        end
        n_cmp++;
        if (ce_n != 2) begin
            n_fail++;
            $display("FAIL b2b_ce_count: got %0d expected 2", ce_n);
        end
    endtask

    task automatic test_conflict();
        logic seen, swe; int ce_n; logic [AW-1:0] sa; logic [31:0] swd;
        do_txn(1'b1, 1'b1, 32'h4C, 32'hA5A5A5A5, 32'h0, 1'b0, seen, ce_n, sa, swe, swd);
        n_cmp++;
        if (ce_n != 1 || swe !== 1'b1 || sa !== 14'h13 || mem0[14'h13] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL conflict_write: got ce %0d we %0b addr %h mem %08h expected 1/1/0013/a5a5a5a5",
                     ce_n, swe, sa, mem0[14'h13]);
        end
    endtask

    task automatic test_reset_abort();
        int nd;
        @(posedge clk); #1;
        dmem_read = 1'b1; mem_addr = 32'h40;
        @(posedge clk);   // accepted, ACCESS
        @(posedge clk);   // WAIT
        #2;
        n_cmp++;
        if (busy !== 1'b1 || sram_addr !== 14'h10) begin
            n_fail++;
            $display("FAIL abort_precond: got busy %0b addr %h expected 1/0010", busy, sram_addr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({resp_rdata, resp_done, resp_err, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL abort_resp_zero: got %08h/%0b/%0b/%0b expected all 0", resp_rdata, resp_done, resp_err, busy);
        end
        n_cmp++;
        if ({sram_ce, sram_we, sram_addr, sram_wdata} !== 48'd0) begin
            n_fail++;
            $display("FAIL abort_sram_zero: got ce %0b we %0b addr %h wdata %h expected all 0", sram_ce, sram_we, sram_addr, sram_wdata);
        end
        dmem_read = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_done) nd++;
        end
        n_cmp++;
        if (nd != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses busy %0b expected 0/0", nd, busy);
        end
    endtask

    task automatic test_sweep();
        int t, d1, d15, bad;
        logic [31:0] r1, r15;
        logic e1, e15;
        @(posedge clk); #1;
        rd1 = 1'b1; rd15 = 1'b1; addr_s = 32'h40; t = cyc;
        d1 = -1; d15 = -1; bad = 0; r1 = 32'd0; r15 = 32'd0; e1 = 1'b1; e15 = 1'b1;
        for (int i = 0; i < 40 && (d1 < 0 || d15 < 0); i++) begin
            @(negedge clk);
            if (ce1 && (we1 || wdata1 != 32'd0)) bad++;
            if (ce15 && (we15 || wdata15 != 32'd0)) bad++;
            if (done1 && d1 < 0) begin d1 = cyc; r1 = rdata1; e1 = err1; rd1 = 1'b0; end
            if (done15 && d15 < 0) begin d15 = cyc; r15 = rdata15; e15 = err15; rd15 = 1'b0; end
        end
        n_cmp++;
        if (d1 != t + 3) begin
            n_fail++;
            $display("FAIL sweep_w1_latency: got done at t+%0d expected t+3", d1 - t);
        end
        n_cmp++;
        if (d15 != t + 17) begin
            n_fail++;
            $display("FAIL sweep_w15_latency: got done at t+%0d expected t+17", d15 - t);
        end
        n_cmp++;
        if (r1 !== 32'hDEADBEEF || r15 !== 32'hDEADBEEF || e1 !== 1'b0 || e15 !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_data: got %08h/%08h err %0b/%0b expected deadbeef/deadbeef 0/0", r1, r15, e1, e15);
        end
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (bad != 0 || busy1 !== 1'b0 || busy15 !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_idle: got bad ce %0d busy %0b/%0b expected 0/0/0", bad, busy1, busy15);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_out_of_range();
        test_ignore_changes();
        test_back_to_back();
        test_conflict();
        test_read();
        test_reset_abort();
        test_sweep();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending responses expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
